reservation_station_aged: RTL and testbench
===========================================

// Module: reservation_station_aged
// PURPOSE
//  Parametrised reservation station feeding one execution unit (ALU or branch unit).
//  Sits between decoder/dispatch and the execution unit, and snoops N CDB channels.
//  Adds four features:
//   - oldest-first issue via an age matrix;
//   - same-cycle CDB bypass at dispatch;
//   - valid/ready back-pressure from the execution unit;
//   - full flush on branch mispredict.
// PARAMETERS
//  RS_DEPTH   16  number of entries, 2..32
//  DATA_W     32  operand / pc / imm width
//  ROB_W      4   ROB tag width; tag 0 means "no dependency / no destination"
//  OP_W       6   operation code width; NOP = 0
//  CDB_PORTS  2   number of CDB broadcast channels snooped
// PORTS
//  clk             in   1                  clock; all state updates on rising edge
//  rst             in   1                  synchronous, active-high reset
//  ena             in   1                  global enable; low freezes all state (CDB ignored)
//  flush           in   1                  mispredict; clears the station
//  assignment_ena  in   1                  dispatch request
//  in_op           in   OP_W               operation
//  in_Qj/in_Qk     in   ROB_W each         source tags (0 = value valid)
//  in_Vj/in_Vk     in   DATA_W each        source values
//  in_imm/in_pc    in   DATA_W each        immediate, pc
//  in_rd_rob       in   ROB_W              destination ROB tag
//  in_has_rd_dest  in   1                  0 -> stored dest tag forced to 0
//  in_cdb_valid    in   CDB_PORTS          per-channel broadcast valid
//  in_cdb_tag      in   CDB_PORTS*ROB_W    packed tags, channel 0 in LSBs
//  in_cdb_data     in   CDB_PORTS*DATA_W   packed data, channel 0 in LSBs
//  out_valid       out  1                  issue register holds an instruction
//  out_ready       in   1                  execution unit accepts this cycle
//  out_op          out  OP_W               issued operation
//  out_Vj/out_Vk   out  DATA_W each        issued operands
//  out_imm/out_pc  out  DATA_W each        issued immediate, pc
//  out_rob_tag     out  ROB_W              issued destination tag
//  has_capacity    out  1                  combinational; >=1 free entry (from registered state)
//  occupancy       out  clog2(RS_DEPTH+1)  registered count of busy entries
// BEHAVIOUR
//  Reset
//   - All busy=0, age matrix=0, out_valid=0, out_op=NOP, other outputs 0, occupancy=0.
//   - rst overrides ena and flush.
//  Dispatch
//   - Accepted iff ena & assignment_ena & has_capacity & ~flush.
//   - Written into the lowest-index free entry; free status is taken from start-of-cycle state.
//   - An entry issued this cycle is not reused until the next cycle.
//   - Request while full is dropped silently; the decoder must gate on has_capacity.
//  Bypass
//   - If in_Qj (or in_Qk) is nonzero and equals a valid CDB tag in the dispatch cycle,
//     store that CDB data and Q=0.
//  CDB snoop
//   - Each busy entry with nonzero Qj/Qk that matches a valid channel captures the data and Q<=0.
//   - Tag 0 never matches.
//   - Multiple channels with the same tag: lowest channel index wins.
//  Ready / select
//   - ready[i] = busy & Qj==0 & Qk==0, using registered Q only.
//   - An operand captured this cycle is issuable next cycle (1-cycle wakeup).
//   - Age matrix: older[j][k] is set for all busy j when k is dispatched; row and column k
//     are cleared when k is freed.
//   - Selected entry is the ready entry with no ready entry older than it.
//  Issue
//   - Fires when (~out_valid | out_ready) and a ready entry exists.
//   - Fields load into the out_* registers, out_valid<=1, and the entry is freed the same edge.
//   - out_valid & ~out_ready: outputs hold stable, no entry is freed.
//   - out_ready with nothing ready: out_valid<=0, out_op<=NOP.
//   - Latency: ready at edge t means out_valid at edge t+1.
//  Flush
//   - On the next edge: all busy=0, ages=0, out_valid=0, occupancy=0.
//   - Same-cycle dispatch and issue are discarded.
//   - has_capacity is high in the following cycle.
//  occupancy
//   - Updated every cycle as +dispatch -issue; simultaneous dispatch and issue leave it unchanged.
// STRUCTURE
//  - Shared constants header: NOP, ZERO_ROB, TRUE/FALSE.
//  - Shared function: clog2.
//  - One sub-module, rs_age_picker(RS_DEPTH): age matrix plus oldest-ready one-hot selection
//    and its encoder.
//  - Free-entry selection is a parametrised lowest-index priority encoder (generate loop).
// TESTING
//  1. rst, then dispatch op=ADD Qj=0 Qk=0 Vj=5 Vk=7 rd=3, out_ready=1
//     -> out_valid at next edge, out_Vj=5, out_Vk=7, out_rob_tag=3; occupancy back to 0.
//  2. Dispatch A(Qj=2) then B(ready), out_ready=1 -> B issues first.
//     CDB ch1 tag=2 data=9 -> A issues 1 cycle later with out_Vj=9.
//  3. Dispatch C(Qk=4) then D(Qk=4); CDB tag=4 data=0x10 -> C issues before D (oldest first),
//     both with Vk=0x10.
//  4. Dispatch with in_Qj=6 while CDB ch0 broadcasts tag 6 data=0xAB -> entry ready, issued next edge.
//  5. Fill RS_DEPTH entries -> has_capacity=0 and the next dispatch is dropped.
//     Hold out_ready=0 -> outputs stable for 3 cycles.
//  6. Flush with 5 busy entries plus same-cycle dispatch -> next edge occupancy=0, out_valid=0,
//     and a later CDB for old tags changes nothing.

Source files
------------

// File: rtl/reservation_station_aged_pkg.sv
// Shared constants and helpers for the aged reservation station slice.
// Imported by the interface, the age picker and the top level.
package reservation_station_aged_pkg;

    localparam logic TRUE     = 1'b1;
    localparam logic FALSE    = 1'b0;
    localparam int   NOP      = 0;
    localparam int   ZERO_ROB = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/reservation_station_aged_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation station.
// master = decoder / CDB / execution-unit side, slave = the station.
interface reservation_station_aged_if
#(
    parameter int RS_DEPTH  = 16,
    parameter int DATA_W    = 32,
    parameter int ROB_W     = 4,
    parameter int OP_W      = 6,
    parameter int CDB_PORTS = 2
);
    import reservation_station_aged_pkg::*;

    localparam int OCC_W = clog2(RS_DEPTH + 1);

    logic                        ena;
    logic                        flush;
    logic                        assignment_ena;
    logic [OP_W-1:0]             in_op;
    logic [ROB_W-1:0]            in_Qj;
    logic [ROB_W-1:0]            in_Qk;
    logic [DATA_W-1:0]           in_Vj;
    logic [DATA_W-1:0]           in_Vk;
    logic [DATA_W-1:0]           in_imm;
    logic [DATA_W-1:0]           in_pc;
    logic [ROB_W-1:0]            in_rd_rob;
    logic                        in_has_rd_dest;
    logic [CDB_PORTS-1:0]        in_cdb_valid;
    logic [CDB_PORTS*ROB_W-1:0]  in_cdb_tag;
    logic [CDB_PORTS*DATA_W-1:0] in_cdb_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [OP_W-1:0]             out_op;
    logic [DATA_W-1:0]           out_Vj;
    logic [DATA_W-1:0]           out_Vk;
    logic [DATA_W-1:0]           out_imm;
    logic [DATA_W-1:0]           out_pc;
    logic [ROB_W-1:0]            out_rob_tag;
    logic                        has_capacity;
    logic [OCC_W-1:0]            occupancy;

    modport master (
        output ena, flush, assignment_ena, in_op, in_Qj, in_Qk, in_Vj, in_Vk,
               in_imm, in_pc, in_rd_rob, in_has_rd_dest, in_cdb_valid, in_cdb_tag,
               in_cdb_data, out_ready,
        input  out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag,
               has_capacity, occupancy
    );

    modport slave (
        input  ena, flush, assignment_ena, in_op, in_Qj, in_Qk, in_Vj, in_Vk,
               in_imm, in_pc, in_rd_rob, in_has_rd_dest, in_cdb_valid, in_cdb_tag,
               in_cdb_data, out_ready,
        output out_valid, out_op, out_Vj, out_Vk, out_imm, out_pc, out_rob_tag,
               has_capacity, occupancy
    );

endinterface

// File: rtl/reservation_station_aged_rs_age_picker.sv
// Age matrix plus oldest-ready selection: older_q[j][k] means entry j was
// dispatched before entry k. Produces a one-hot pick and its index.
module rs_age_picker
    import reservation_station_aged_pkg::*;
#(
    parameter  int RS_DEPTH = 16,
    localparam int IDX_W    = clog2(RS_DEPTH)
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [RS_DEPTH-1:0] busy,
    input  logic [RS_DEPTH-1:0] ready,
    input  logic [RS_DEPTH-1:0] alloc_oh,
    input  logic [RS_DEPTH-1:0] free_oh,
    output logic [RS_DEPTH-1:0] sel_oh,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                sel_valid
);

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
    logic                              blocked;

    // A freed entry loses its row and column even if another entry is dispatched the same edge.
    always_comb begin
        older_d = older_q;
        for (int j = 0; j < RS_DEPTH; j++) begin
            for (int k = 0; k < RS_DEPTH; k++) begin
                if (clear || free_oh[j] || free_oh[k])
                    older_d[j][k] = FALSE;
                else if (alloc_oh[k])
                    older_d[j][k] = busy[j];
                else if (alloc_oh[j])
                    older_d[j][k] = FALSE;
            end
        end
    end

    always_comb begin
        sel_oh  = '0;
        blocked = FALSE;
        for (int i = 0; i < RS_DEPTH; i++) begin
            blocked = FALSE;
            for (int j = 0; j < RS_DEPTH; j++)
                if (ready[j] && older_q[j][i]) blocked = TRUE;
            sel_oh[i] = ready[i] & ~blocked;
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++)
            if (sel_oh[i]) sel_idx = IDX_W'(i);
    end

    assign sel_valid = |sel_oh;

    always_ff @(posedge clk) begin
        if (rst) older_q <= '0;
        else     older_q <= older_d;
    end

endmodule

// File: rtl/reservation_station_aged.sv
// Reservation station with oldest-first issue, dispatch-time CDB bypass,
// valid/ready issue register and full flush on mispredict.
module reservation_station_aged
    import reservation_station_aged_pkg::*;
#(
    parameter int RS_DEPTH  = 16,
    parameter int DATA_W    = 32,
    parameter int ROB_W     = 4,
    parameter int OP_W      = 6,
    parameter int CDB_PORTS = 2
)(
    input logic                       clk,
    input logic                       rst,
    reservation_station_aged_if.slave bus
);

    localparam int IDX_W = clog2(RS_DEPTH);
    localparam int OCC_W = clog2(RS_DEPTH + 1);

    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [OP_W-1:0]     op_q  [RS_DEPTH], op_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q  [RS_DEPTH], qj_d  [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q  [RS_DEPTH], qk_d  [RS_DEPTH];
    logic [ROB_W-1:0]    rob_q [RS_DEPTH], rob_d [RS_DEPTH];
    logic [DATA_W-1:0]   vj_q  [RS_DEPTH], vj_d  [RS_DEPTH];
    logic [DATA_W-1:0]   vk_q  [RS_DEPTH], vk_d  [RS_DEPTH];
    logic [DATA_W-1:0]   imm_q [RS_DEPTH], imm_d [RS_DEPTH];
    logic [DATA_W-1:0]   pc_q  [RS_DEPTH], pc_d  [RS_DEPTH];

    logic                out_valid_q, out_valid_d;
    logic [OP_W-1:0]     out_op_q, out_op_d;
    logic [DATA_W-1:0]   out_vj_q, out_vj_d, out_vk_q, out_vk_d;
    logic [DATA_W-1:0]   out_imm_q, out_imm_d, out_pc_q, out_pc_d;
    logic [ROB_W-1:0]    out_rob_q, out_rob_d;
    logic [OCC_W-1:0]    occ_q, occ_d;

    logic [RS_DEPTH-1:0] free_vec, alloc_oh, ready, sel_oh, alloc_fire, free_fire;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_valid, dispatch, issue;
    logic [DATA_W:0]     lookup;

    // Returns {hit, value}; the lowest matching channel wins and tag 0 never matches.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]            tag,
        input logic [DATA_W-1:0]           cur,
        input logic [CDB_PORTS-1:0]        valid,
        input logic [CDB_PORTS*ROB_W-1:0]  tags,
        input logic [CDB_PORTS*DATA_W-1:0] data
    );
        logic [DATA_W:0] result;
        result = {FALSE, cur};
        for (int c = CDB_PORTS - 1; c >= 0; c--)
            if (tag != '0 && valid[c] && tags[c*ROB_W +: ROB_W] == tag)
                result = {TRUE, data[c*DATA_W +: DATA_W]};
        return result;
    endfunction

    assign free_vec = ~busy_q;

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_entry
        if (i == 0) begin : g_first
            assign alloc_oh[i] = free_vec[0];
        end else begin : g_rest
            assign alloc_oh[i] = free_vec[i] & ~(|free_vec[i-1:0]);
        end
        assign ready[i] = busy_q[i] && qj_q[i] == '0 && qk_q[i] == '0;
    end

    assign bus.has_capacity = |free_vec;
    assign dispatch   = bus.ena & bus.assignment_ena & bus.has_capacity & ~bus.flush;
    assign issue      = bus.ena & ~bus.flush & sel_valid & (~out_valid_q | bus.out_ready);
    assign alloc_fire = dispatch ? alloc_oh : '0;
    assign free_fire  = issue ? sel_oh : '0;

    rs_age_picker #(.RS_DEPTH(RS_DEPTH)) u_picker (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.ena & bus.flush),
        .busy      (busy_q),
        .ready     (ready),
        .alloc_oh  (alloc_fire),
        .free_oh   (free_fire),
        .sel_oh    (sel_oh),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid)
    );

    always_comb begin
        busy_d = busy_q;  op_d = op_q;  qj_d = qj_q;  qk_d = qk_q;  rob_d = rob_q;
        vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;  pc_d = pc_q;
        out_valid_d = out_valid_q;  out_op_d = out_op_q;  out_vj_d = out_vj_q;
        out_vk_d = out_vk_q;  out_imm_d = out_imm_q;  out_pc_d = out_pc_q;
        out_rob_d = out_rob_q;  occ_d = occ_q;
        lookup = '0;
        if (bus.ena) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy_q[i]) begin
                    lookup = cdb_lookup(qj_q[i], vj_q[i], bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    vj_d[i] = lookup[DATA_W-1:0];
                    if (lookup[DATA_W]) qj_d[i] = ROB_W'(ZERO_ROB);
                    lookup = cdb_lookup(qk_q[i], vk_q[i], bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    vk_d[i] = lookup[DATA_W-1:0];
                    if (lookup[DATA_W]) qk_d[i] = ROB_W'(ZERO_ROB);
                end
            end
            busy_d = busy_q & ~free_fire;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (alloc_fire[i]) begin
                    busy_d[i] = TRUE;
                    op_d[i]   = bus.in_op;
                    imm_d[i]  = bus.in_imm;
                    pc_d[i]   = bus.in_pc;
                    rob_d[i]  = bus.in_has_rd_dest ? bus.in_rd_rob : ROB_W'(ZERO_ROB);
                    lookup    = cdb_lookup(bus.in_Qj, bus.in_Vj, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    vj_d[i]   = lookup[DATA_W-1:0];
                    qj_d[i]   = lookup[DATA_W] ? ROB_W'(ZERO_ROB) : bus.in_Qj;
                    lookup    = cdb_lookup(bus.in_Qk, bus.in_Vk, bus.in_cdb_valid, bus.in_cdb_tag, bus.in_cdb_data);
                    vk_d[i]   = lookup[DATA_W-1:0];
                    qk_d[i]   = lookup[DATA_W] ? ROB_W'(ZERO_ROB) : bus.in_Qk;
                end
            end
            if (issue) begin
                out_valid_d = TRUE;
                out_op_d    = op_q[sel_idx];
                out_vj_d    = vj_q[sel_idx];
                out_vk_d    = vk_q[sel_idx];
                out_imm_d   = imm_q[sel_idx];
                out_pc_d    = pc_q[sel_idx];
                out_rob_d   = rob_q[sel_idx];
            end else if (bus.out_ready) begin
                out_valid_d = FALSE;
                out_op_d    = OP_W'(NOP);
            end
            occ_d = occ_q + OCC_W'(dispatch) - OCC_W'(issue);
            // Flush wins over everything computed above for this edge.
            if (bus.flush) begin
                busy_d      = '0;
                out_valid_d = FALSE;
                out_op_d    = OP_W'(NOP);
                occ_d       = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            op_q   <= '{default: '0};  qj_q  <= '{default: '0};  qk_q <= '{default: '0};
            rob_q  <= '{default: '0};  vj_q  <= '{default: '0};  vk_q <= '{default: '0};
            imm_q  <= '{default: '0};  pc_q  <= '{default: '0};
            out_valid_q <= FALSE;  out_op_q <= OP_W'(NOP);  out_vj_q <= '0;  out_vk_q <= '0;
            out_imm_q   <= '0;     out_pc_q <= '0;          out_rob_q <= ROB_W'(ZERO_ROB);
            occ_q       <= '0;
        end else begin
            busy_q <= busy_d;
            op_q   <= op_d;   qj_q  <= qj_d;   qk_q <= qk_d;
            rob_q  <= rob_d;  vj_q  <= vj_d;   vk_q <= vk_d;
            imm_q  <= imm_d;  pc_q  <= pc_d;
            out_valid_q <= out_valid_d;  out_op_q <= out_op_d;  out_vj_q <= out_vj_d;
            out_vk_q    <= out_vk_d;     out_imm_q <= out_imm_d; out_pc_q <= out_pc_d;
            out_rob_q   <= out_rob_d;    occ_q <= occ_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = out_op_q;
    assign bus.out_Vj      = out_vj_q;
    assign bus.out_Vk      = out_vk_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_rob_tag = out_rob_q;
    assign bus.occupancy   = occ_q;

endmodule

// File: tb/tb_reservation_station_aged.sv
// Directed bench for reservation_station_aged: reset, issue, wakeup, age order,
// bypass, full/back-pressure and flush scenarios with hand-computed expectations.
module tb_reservation_station_aged;

    localparam int RS_DEPTH  = 16;
    localparam int DATA_W    = 32;
    localparam int ROB_W     = 4;
    localparam int OP_W      = 6;
    localparam int CDB_PORTS = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reservation_station_aged_if #(
        .RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)
    ) bus ();

    reservation_station_aged #(
        .RS_DEPTH(RS_DEPTH), .DATA_W(DATA_W), .ROB_W(ROB_W), .OP_W(OP_W), .CDB_PORTS(CDB_PORTS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ena = 1'b1;  bus.flush = 1'b0;  bus.assignment_ena = 1'b0;
        bus.in_op = '0;  bus.in_Qj = '0;  bus.in_Qk = '0;  bus.in_Vj = '0;  bus.in_Vk = '0;
        bus.in_imm = '0; bus.in_pc = '0;  bus.in_rd_rob = '0;  bus.in_has_rd_dest = 1'b0;
        bus.in_cdb_valid = '0;  bus.in_cdb_tag = '0;  bus.in_cdb_data = '0;  bus.out_ready = 1'b0;
    endtask

    task automatic drive_dispatch(input logic [5:0] op, input logic [3:0] qj, input logic [3:0] qk,
                                  input logic [31:0] vj, input logic [31:0] vk,
                                  input logic [3:0] rd, input logic has_rd);
        bus.assignment_ena = 1'b1;
        bus.in_op = op;  bus.in_Qj = qj;  bus.in_Qk = qk;  bus.in_Vj = vj;  bus.in_Vk = vk;
        bus.in_imm = 32'h100 + {28'd0, rd};
        bus.in_pc  = 32'h1000 + {26'd0, rd, 2'b00};
        bus.in_rd_rob = rd;  bus.in_has_rd_dest = has_rd;
    endtask

    task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
        bus.in_cdb_valid[ch] = 1'b1;
        bus.in_cdb_tag[ch*ROB_W +: ROB_W] = tag;
        bus.in_cdb_data[ch*DATA_W +: DATA_W] = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        drive_dispatch(6'd1, 4'd0, 4'd0, 32'd1, 32'd2, 4'd1, 1'b1);
        step(); step();
        clear_inputs();
        rst = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0d want 0", bus.out_valid); end
        checks++; if (bus.out_op !== 6'd0) begin errors++; $display("[TB] FAIL reset_op got %0d want 0", bus.out_op); end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", bus.occupancy); end
        checks++; if (bus.has_capacity !== 1'b1) begin errors++; $display("[TB] FAIL reset_cap got %0d want 1", bus.has_capacity); end
        checks++; if (bus.out_rob_tag !== 4'd0) begin errors++; $display("[TB] FAIL reset_rob got %0d want 0", bus.out_rob_tag); end
        checks++; if (bus.out_Vj !== 32'd0) begin errors++; $display("[TB] FAIL reset_vj got %0h want 0", bus.out_Vj); end
    endtask

    task automatic test_basic_issue();
        bus.out_ready = 1'b1;
        drive_dispatch(6'd1, 4'd0, 4'd0, 32'd5, 32'd7, 4'd3, 1'b1);
        step();
        checks++; if (bus.occupancy !== 5'd1) begin errors++; $display("[TB] FAIL basic_occ1 got %0d want 1", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early got %0d want 0", bus.out_valid); end
        bus.assignment_ena = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %0d want 1", bus.out_valid); end
        checks++; if (bus.out_op !== 6'd1) begin errors++; $display("[TB] FAIL basic_op got %0d want 1", bus.out_op); end
        checks++; if (bus.out_Vj !== 32'd5) begin errors++; $display("[TB] FAIL basic_vj got %0d want 5", bus.out_Vj); end
        checks++; if (bus.out_Vk !== 32'd7) begin errors++; $display("[TB] FAIL basic_vk got %0d want 7", bus.out_Vk); end
        checks++; if (bus.out_rob_tag !== 4'd3) begin errors++; $display("[TB] FAIL basic_rob got %0d want 3", bus.out_rob_tag); end
        checks++; if (bus.out_imm !== 32'h103) begin errors++; $display("[TB] FAIL basic_imm got %0h want 103", bus.out_imm); end
        checks++; if (bus.out_pc !== 32'h100c) begin errors++; $display("[TB] FAIL basic_pc got %0h want 100c", bus.out_pc); end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("[TB] FAIL basic_occ0 got %0d want 0", bus.occupancy); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain got %0d want 0", bus.out_valid); end
        checks++; if (bus.out_op !== 6'd0) begin errors++; $display("[TB] FAIL basic_nop got %0d want 0", bus.out_op); end
    endtask

    task automatic test_wakeup();
        bus.out_ready = 1'b1;
        drive_dispatch(6'd2, 4'd2, 4'd0, 32'd0, 32'h22, 4'd5, 1'b1);
        step();
        drive_dispatch(6'd3, 4'd0, 4'd0, 32'd11, 32'd12, 4'd6, 1'b1);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_idle got %0d want 0", bus.out_valid); end
        bus.assignment_ena = 1'b0;
        set_cdb(1, 4'd2, 32'd9);
        set_cdb(0, 4'd7, 32'h55);
        step();
        checks++; if (bus.out_rob_tag !== 4'd6) begin errors++; $display("[TB] FAIL wake_b_rob got %0d want 6", bus.out_rob_tag); end
        checks++; if (bus.out_Vj !== 32'd11) begin errors++; $display("[TB] FAIL wake_b_vj got %0d want 11", bus.out_Vj); end
        bus.in_cdb_valid = '0;
        step();
        checks++; if (bus.out_rob_tag !== 4'd5) begin errors++; $display("[TB] FAIL wake_a_rob got %0d want 5", bus.out_rob_tag); end
        checks++; if (bus.out_Vj !== 32'd9) begin errors++; $display("[TB] FAIL wake_a_vj got %0d want 9", bus.out_Vj); end
        checks++; if (bus.out_Vk !== 32'h22) begin errors++; $display("[TB] FAIL wake_a_vk got %0h want 22", bus.out_Vk); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL wake_drain got %0d want 0", bus.out_valid); end
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("[TB] FAIL wake_occ got %0d want 0", bus.occupancy); end
    endtask

    task automatic test_oldest_first();
        bus.out_ready = 1'b1;
        drive_dispatch(6'd6, 4'd0, 4'd0, 32'd1, 32'd1, 4'd9, 1'b1);
        step();
        drive_dispatch(6'd4, 4'd0, 4'd4, 32'd1, 32'd0, 4'd7, 1'b1);
        step();
        checks++; if (bus.out_rob_tag !== 4'd9) begin errors++; $display("[TB] FAIL age_f_rob got %0d want 9", bus.out_rob_tag); end
        checks++; if (bus.occupancy !== 5'd1) begin errors++; $display("[TB] FAIL age_occ_same got %0d want 1", bus.occupancy); end
        drive_dispatch(6'd5, 4'd0, 4'd4, 32'd2, 32'd0, 4'd8, 1'b1);
        step();
        checks++; if (bus.occupancy !== 5'd2) begin errors++; $display("[TB] FAIL age_occ2 got %0d want 2", bus.occupancy); end
        bus.assignment_ena = 1'b0;
        set_cdb(0, 4'd4, 32'h10);
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL age_wakeup_lat got %0d want 0", bus.out_valid); end
        bus.in_cdb_valid = '0;
        step();
        checks++; if (bus.out_rob_tag !== 4'd7) begin errors++; $display("[TB] FAIL age_c_first got %0d want 7", bus.out_rob_tag); end
        checks++; if (bus.out_Vk !== 32'h10) begin errors++; $display("[TB] FAIL age_c_vk got %0h want 10", bus.out_Vk); end
        step();
        checks++; if (bus.out_rob_tag !== 4'd8) begin errors++; $display("[TB] FAIL age_d_second got %0d want 8", bus.out_rob_tag); end
        checks++; if (bus.out_Vk !== 32'h10) begin errors++; $display("[TB] FAIL age_d_vk got %0h want 10", bus.out_Vk); end
        checks++; if (bus.out_Vj !== 32'd2) begin errors++; $display("[TB] FAIL age_d_vj got %0d want 2", bus.out_Vj); end
        step();
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b1;
        drive_dispatch(6'd7, 4'd6, 4'd6, 32'd0, 32'd0, 4'd10, 1'b1);
        set_cdb(0, 4'd6, 32'hAB);
        set_cdb(1, 4'd6, 32'hCD);
        step();
        bus.in_cdb_valid = '0;
        drive_dispatch(6'd8, 4'd0, 4'd0, 32'd3, 32'd4, 4'd12, 1'b0);
        step();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL byp_valid got %0d want 1", bus.out_valid); end
        checks++; if (bus.out_rob_tag !== 4'd10) begin errors++; $display("[TB] FAIL byp_rob got %0d want 10", bus.out_rob_tag); end
        checks++; if (bus.out_Vj !== 32'hAB) begin errors++; $display("[TB] FAIL byp_vj got %0h want ab", bus.out_Vj); end
        checks++; if (bus.out_Vk !== 32'hAB) begin errors++; $display("[TB] FAIL byp_vk got %0h want ab", bus.out_Vk); end
        bus.assignment_ena = 1'b0;
        step();
        checks++; if (bus.out_op !== 6'd8) begin errors++; $display("[TB] FAIL nodest_op got %0d want 8", bus.out_op); end
        checks++; if (bus.out_rob_tag !== 4'd0) begin errors++; $display("[TB] FAIL nodest_rob got %0d want 0", bus.out_rob_tag); end
        step();
    endtask

    task automatic test_full_backpressure();
        bus.out_ready = 1'b0;
        drive_dispatch(6'd9, 4'd0, 4'd0, 32'h77, 32'h78, 4'd1, 1'b1);
        step();
        for (int i = 0; i < RS_DEPTH; i++) begin
            drive_dispatch(6'(16 + i), (i == 0) ? 4'd0 : 4'd15, 4'd0, 32'(i), 32'(i),
                           (i == 0) ? 4'd2 : 4'd3, 1'b1);
            step();
        end
        checks++; if (bus.occupancy !== 5'd16) begin errors++; $display("[TB] FAIL full_occ got %0d want 16", bus.occupancy); end
        checks++; if (bus.has_capacity !== 1'b0) begin errors++; $display("[TB] FAIL full_cap got %0d want 0", bus.has_capacity); end
        drive_dispatch(6'd30, 4'd0, 4'd0, 32'd0, 32'd0, 4'd14, 1'b1);
        step();
        checks++; if (bus.occupancy !== 5'd16) begin errors++; $display("[TB] FAIL full_drop got %0d want 16", bus.occupancy); end
        bus.assignment_ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_rob_tag !== 4'd1 || bus.out_Vj !== 32'h77) begin
                errors++; $display("[TB] FAIL stall_hold cycle %0d got v=%0d rob=%0d vj=%0h want v=1 rob=1 vj=77",
                                   k, bus.out_valid, bus.out_rob_tag, bus.out_Vj);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_rob_tag !== 4'd2 || bus.out_op !== 6'd16) begin
            errors++; $display("[TB] FAIL full_release got rob=%0d op=%0d want rob=2 op=16", bus.out_rob_tag, bus.out_op);
        end
        checks++; if (bus.occupancy !== 5'd15) begin errors++; $display("[TB] FAIL full_occ15 got %0d want 15", bus.occupancy); end
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_blocked got %0d want 0", bus.out_valid); end
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        checks++; if (bus.occupancy !== 5'd0 || bus.has_capacity !== 1'b1) begin
            errors++; $display("[TB] FAIL full_flush got occ=%0d cap=%0d want occ=0 cap=1", bus.occupancy, bus.has_capacity);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive_dispatch(6'd11, 4'd0, 4'd0, 32'h44, 32'd0, 4'd11, 1'b1);
        step();
        for (int i = 1; i <= 5; i++) begin
            drive_dispatch(6'(20 + i), 4'd13, 4'd0, 32'd0, 32'd0, 4'(i), 1'b1);
            step();
        end
        checks++; if (bus.occupancy !== 5'd5) begin errors++; $display("[TB] FAIL flush_pre_occ got %0d want 5", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rob_tag !== 4'd11) begin
            errors++; $display("[TB] FAIL flush_pre_out got v=%0d rob=%0d want v=1 rob=11", bus.out_valid, bus.out_rob_tag);
        end
        bus.flush = 1'b1;
        drive_dispatch(6'd12, 4'd0, 4'd0, 32'd1, 32'd1, 4'd12, 1'b1);
        step();
        bus.flush = 1'b0;
        bus.assignment_ena = 1'b0;
        checks++; if (bus.occupancy !== 5'd0) begin errors++; $display("[TB] FAIL flush_occ got %0d want 0", bus.occupancy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0d want 0", bus.out_valid); end
        checks++; if (bus.has_capacity !== 1'b1) begin errors++; $display("[TB] FAIL flush_cap got %0d want 1", bus.has_capacity); end
        bus.out_ready = 1'b1;
        set_cdb(0, 4'd13, 32'h99);
        step();
        bus.in_cdb_valid = '0;
        step(); step();
        checks++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 5'd0) begin
            errors++; $display("[TB] FAIL flush_stale got v=%0d occ=%0d want v=0 occ=0", bus.out_valid, bus.occupancy);
        end
        drive_dispatch(6'd13, 4'd0, 4'd0, 32'h21, 32'h22, 4'd4, 1'b1);
        step();
        bus.assignment_ena = 1'b0;
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rob_tag !== 4'd4 || bus.out_Vj !== 32'h21) begin
            errors++; $display("[TB] FAIL flush_after got v=%0d rob=%0d vj=%0h want v=1 rob=4 vj=21",
                               bus.out_valid, bus.out_rob_tag, bus.out_Vj);
        end
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_issue();
        test_wakeup();
        test_oldest_first();
        test_bypass();
        test_full_backpressure();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
